vga_fb_fill_arbiter: RTL
========================

Name: vga_fb_fill_arbiter

Overview:
Shares the single framebuffer write port (17-bit address, 12-bit RGB, 320x240) between the OTTER MCU and a hardware rectangle-fill engine.
- MCU writes always win.
- The fill engine issues one pixel write per cycle whenever the MCU does not write.
- The block sits between the MCU memory-mapped write signals and the framebuffer's WA/WD/WE inputs.

Parameters:
H_RES, 320, horizontal framebuffer resolution in pixels
V_RES, 240, vertical framebuffer resolution in pixels
ADDR_W, 17, framebuffer address width
COLOR_W, 12, pixel width (4R:4G:4B)

Ports:
CLK_50MHz  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CPU_WA  in  17  MCU write address (row*320+col)
CPU_WD  in  12  MCU write data
CPU_WE  in  1  MCU write enable
FILL_X0  in  9  rectangle origin column
FILL_Y0  in  8  rectangle origin row
FILL_W  in  9  rectangle width in pixels
FILL_H  in  8  rectangle height in pixels
FILL_COLOR  in  12  fill colour
FILL_START  in  1  start request, sampled only in IDLE
FILL_BUSY  out  1  fill in progress
FILL_DONE  out  1  one-cycle completion pulse
FB_WA  out  17  framebuffer write address
FB_WD  out  12  framebuffer write data
FB_WE  out  1  framebuffer write enable

Behaviour:
- Reset (RST_N low, async): FB_WA=0, FB_WD=0, FB_WE=0, FILL_BUSY=0, FILL_DONE=0, FSM=IDLE. Reset mid-fill abandons the fill and no further writes are issued. On release the FSM starts from IDLE.
- All outputs are registered. Port latency is 1 cycle: inputs sampled at edge N appear on FB_* after edge N.
- Arbitration, each edge:
  - If CPU_WE=1, register CPU_WA/CPU_WD with FB_WE=1. The fill engine holds its position and loses no pixel.
  - Else, if the FSM is in RUN, register the fill pixel with FB_WE=1.
  - Else, FB_WE=0; FB_WA/FB_WD hold their previous values.
- FSM states: IDLE, SETUP, RUN, DONE.
- IDLE:
  - FILL_START=1 with W!=0, H!=0, X0<H_RES and Y0<V_RES: latch all FILL_* inputs, set FILL_BUSY=1, go to SETUP.
  - FILL_START=1 with an invalid request: go to DONE, set FILL_BUSY=1. No writes are issued.
- SETUP, one cycle:
  - Clip: x_end = min(X0+W, H_RES)-1 and y_end = min(Y0+H, V_RES)-1, computed at 10/9-bit width with no overflow.
  - Row base = Y0*320, computed as (Y0<<8)+(Y0<<6).
  - Set x=X0, y=Y0, then go to RUN.
- RUN: when the engine wins the port, write address = base+x and data = latched colour.
  - If x==x_end: x<=X0, y<=y+1, base<=base+H_RES.
  - Otherwise x<=x+1.
  - When the pixel (x_end, y_end) is granted, go to DONE.
- DONE, one cycle: FILL_DONE=1 and FILL_BUSY=0 are registered on entry, then the FSM returns to IDLE.
- FILL_START while the FSM is not in IDLE is ignored; there is no queueing.
- Unblocked timing:
  - START is sampled at edge E0.
  - The first fill write is visible after E2.
  - The last write (W*H-th pixel) is visible after E(1+W*H).
  - FILL_DONE is high for the cycle after E(2+W*H).
- MCU writes and fill writes may target the same pixel. The last registered write wins; no coherence is enforced.
- Address arithmetic is unsigned and truncated to ADDR_W. The maximum address is 76799.

Decomposition:
- Package vga_fb_pkg holds:
  - constants H_RES, V_RES, FB_ADDR_W, FB_COLOR_W;
  - typedef fill_state_t (IDLE, SETUP, RUN, DONE);
  - function row_base(y), returning y*H_RES via shift-add.
- Sub-module vga_fb_fill_engine holds the FSM, counters and clipping. Its interface:
  - outputs: pixel address, colour, and a valid signal;
  - input: grant = ~CPU_WE.
- The top module holds the priority mux and the output registers.

Test Plan:
- Reset mid-RUN of a 10x10 fill with RST_N pulsed low: all outputs go to 0 immediately, FB_WE stays 0 afterwards, and the FSM is in IDLE.
- START X0=0, Y0=0, W=4, H=2, colour 0xF00, CPU idle: 8 writes on consecutive cycles to addresses 0,1,2,3,320,321,322,323, all with data 0xF00. FILL_DONE pulses once, 10 cycles after E0.
- Same fill with CPU_WE held for 3 cycles after the second fill write (CPU_WA=1000, CPU_WD=0x0AB): the CPU write appears 3 times and the fill resumes at address 2 with no skipped or duplicate pixels. FILL_DONE is delayed by 3 cycles.
- START X0=318, Y0=239, W=5, H=5: clipped to addresses 76798 and 76799 only, then FILL_DONE.
- START with W=0, or with X0=320: no FB_WE from the fill; FILL_DONE pulses 1 cycle after E0.
- Second START asserted during RUN: ignored; exactly W*H writes occur and one FILL_DONE pulse.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared constants, FSM encoding and address helper for the framebuffer fill path.
package vga_fb_pkg;

  localparam int unsigned H_RES      = 320;
  localparam int unsigned V_RES      = 240;
  localparam int unsigned FB_ADDR_W  = 17;
  localparam int unsigned FB_COLOR_W = 12;

  typedef logic [1:0] fill_state_t;

  localparam fill_state_t StIdle  = 2'd0;
  localparam fill_state_t StSetup = 2'd1;
  localparam fill_state_t StRun   = 2'd2;
  localparam fill_state_t StDone  = 2'd3;

  // y * 320 without a multiplier: (y << 8) + (y << 6).
  function automatic logic [FB_ADDR_W-1:0] row_base(input logic [7:0] y);
    logic [FB_ADDR_W-1:0] yw;
    yw = {{(FB_ADDR_W - 8){1'b0}}, y};
    return (yw << 8) + (yw << 6);
  endfunction

endpackage

// File: rtl/vga_fb_fill_engine.sv
// Rectangle-fill engine: FSM, pixel counters and clipping to the framebuffer edges.
module vga_fb_fill_engine
  import vga_fb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [8:0]            x0_i,
  input  logic [7:0]            y0_i,
  input  logic [8:0]            w_i,
  input  logic [7:0]            h_i,
  input  logic [FB_COLOR_W-1:0] color_i,
  input  logic                  grant_i,
  output logic                  pix_valid_o,
  output logic [FB_ADDR_W-1:0]  pix_addr_o,
  output logic [FB_COLOR_W-1:0] pix_color_o,
  output logic                  busy_o,
  output logic                  done_o
);

  fill_state_t           state_q, state_d;
  logic [8:0]            x0_q, x0_d, w_q, w_d, x_q, x_d, x_end_q, x_end_d;
  logic [7:0]            y0_q, y0_d, h_q, h_d, y_q, y_d, y_end_q, y_end_d;
  logic [FB_COLOR_W-1:0] color_q, color_d;
  logic [FB_ADDR_W-1:0]  base_q, base_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic       req_ok;
  logic [9:0] x_sum, x_lim, x_lim_m1;
  logic [8:0] y_sum, y_lim, y_lim_m1;

  assign req_ok = (w_i != 9'd0) && (h_i != 8'd0) && (x0_i < 9'(H_RES)) && (y0_i < 8'(V_RES));

  // Sums are one bit wider than the operands so the clip never wraps.
  assign x_sum    = {1'b0, x0_q} + {1'b0, w_q};
  assign x_lim    = (x_sum > 10'(H_RES)) ? 10'(H_RES) : x_sum;
  assign x_lim_m1 = x_lim - 10'd1;
  assign y_sum    = {1'b0, y0_q} + {1'b0, h_q};
  assign y_lim    = (y_sum > 9'(V_RES)) ? 9'(V_RES) : y_sum;
  assign y_lim_m1 = y_lim - 9'd1;

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    x_d     = x_q;
    y_d     = y_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    base_d  = base_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          busy_d = 1'b1;
          if (req_ok) begin
            x0_d    = x0_i;
            y0_d    = y0_i;
            w_d     = w_i;
            h_d     = h_i;
            color_d = color_i;
            state_d = StSetup;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSetup: begin
        x_end_d = x_lim_m1[8:0];
        y_end_d = y_lim_m1[7:0];
        base_d  = row_base(y0_q);
        x_d     = x0_q;
        y_d     = y0_q;
        state_d = StRun;
      end
      StRun: begin
        if (grant_i) begin
          if (x_q == x_end_q) begin
            if (y_q == y_end_q) begin
              state_d = StDone;
            end else begin
              x_d    = x0_q;
              y_d    = y_q + 8'd1;
              base_d = base_q + FB_ADDR_W'(H_RES);
            end
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pix_valid_o = (state_q == StRun);
  assign pix_addr_o  = base_q + {{(FB_ADDR_W - 9){1'b0}}, x_q};
  assign pix_color_o = color_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: rtl/vga_fb_fill_arbiter.sv
// Framebuffer write-port arbiter: MCU writes take priority, fill engine uses idle cycles.
module vga_fb_fill_arbiter
  import vga_fb_pkg::*;
(
  input  logic                  CLK_50MHz,
  input  logic                  RST_N,
  input  logic [FB_ADDR_W-1:0]  CPU_WA,
  input  logic [FB_COLOR_W-1:0] CPU_WD,
  input  logic                  CPU_WE,
  input  logic [8:0]            FILL_X0,
  input  logic [7:0]            FILL_Y0,
  input  logic [8:0]            FILL_W,
  input  logic [7:0]            FILL_H,
  input  logic [FB_COLOR_W-1:0] FILL_COLOR,
  input  logic                  FILL_START,
  output logic                  FILL_BUSY,
  output logic                  FILL_DONE,
  output logic [FB_ADDR_W-1:0]  FB_WA,
  output logic [FB_COLOR_W-1:0] FB_WD,
  output logic                  FB_WE
);

  logic                  pix_valid;
  logic [FB_ADDR_W-1:0]  pix_addr;
  logic [FB_COLOR_W-1:0] pix_color;
  logic [FB_ADDR_W-1:0]  fb_wa_q;
  logic [FB_COLOR_W-1:0] fb_wd_q;
  logic                  fb_we_q;

  vga_fb_fill_engine u_engine (
    .clk_i       (CLK_50MHz),
    .rst_ni      (RST_N),
    .start_i     (FILL_START),
    .x0_i        (FILL_X0),
    .y0_i        (FILL_Y0),
    .w_i         (FILL_W),
    .h_i         (FILL_H),
    .color_i     (FILL_COLOR),
    .grant_i     (~CPU_WE),
    .pix_valid_o (pix_valid),
    .pix_addr_o  (pix_addr),
    .pix_color_o (pix_color),
    .busy_o      (FILL_BUSY),
    .done_o      (FILL_DONE)
  );

  // Address/data hold their last value when nobody writes.
  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      fb_wa_q <= '0;
      fb_wd_q <= '0;
      fb_we_q <= 1'b0;
    end else if (CPU_WE) begin
      fb_wa_q <= CPU_WA;
      fb_wd_q <= CPU_WD;
      fb_we_q <= 1'b1;
    end else if (pix_valid) begin
      fb_wa_q <= pix_addr;
      fb_wd_q <= pix_color;
      fb_we_q <= 1'b1;
    end else begin
      fb_we_q <= 1'b0;
    end
  end

  assign FB_WA = fb_wa_q;
  assign FB_WD = fb_wd_q;
  assign FB_WE = fb_we_q;

endmodule
